// File: rtl/mcu_mem_pkg.sv
// rtl/mcu_mem_pkg.sv - shared types and default constants for the memory responder
package mcu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        TEXT = 2'd0,
        DATA = 2'd1,
        NONE = 2'd2
    } region_e;

    localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] DATA_BASE_DEFAULT = 32'h1001_0000;

endpackage

// File: rtl/mcu_word_ram.sv
// rtl/mcu_word_ram.sv - synchronous single-port 32-bit word RAM with registered read
module mcu_word_ram #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [0:(1<<ADDR_W)-1];
    logic [31:0] rdata_q;

    // Enabled access: optional write, read returns the pre-write word on the next cycle
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mcu_mem_responder.sv
// rtl/mcu_mem_responder.sv - wait-state memory responder for text/data regions; MCU_MEM_ADDR_CHECK_EN enables address error checking
module mcu_mem_responder
    import mcu_mem_pkg::*;
#(
    parameter int unsigned ADDR_WORDS_LOG2 = 8,
    parameter int unsigned WAIT_CYCLES     = 2,
    parameter logic [31:0] TEXT_BASE       = TEXT_BASE_DEFAULT,
    parameter logic [31:0] DATA_BASE       = DATA_BASE_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        req_ready_o,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    localparam int unsigned AW = ADDR_WORDS_LOG2;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        started_q;
    logic        req_write_q;
    logic [31:0] req_addr_q, req_wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] text_off, data_off;
    region_e     region;
    logic        access_err;
    logic        ram_en, data_we;
    logic [31:0] text_rdata, data_rdata;
    logic        unused_off;

    // State, wait counter and the post-reset ready gate
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            started_q <= 1'b1;
        end
    end

    // Next state: accept in IDLE, count wait states, one ACCESS and one RESP cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i && started_q) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the request fields on accept; they stay stable for the whole transaction
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
        end else if (req_valid_i && req_ready_o) begin
            req_write_q <= req_write_i;
            req_addr_q  <= req_addr_i;
            req_wdata_q <= req_wdata_i;
        end
    end

    // Region decode on the captured address; text takes priority if regions overlap
    always_comb begin
        text_off = req_addr_q - TEXT_BASE;
        data_off = req_addr_q - DATA_BASE;
        region   = NONE;
        if (~|text_off[31:AW+2]) begin
            region = TEXT;
        end else if (~|data_off[31:AW+2]) begin
            region = DATA;
        end
    end

    assign unused_off = ^{text_off[1:0], data_off[1:0]};

`ifdef MCU_MEM_ADDR_CHECK_EN
    assign access_err = (req_addr_q[1:0] != 2'b00) || (region == NONE) ||
                        (req_write_q && (region == TEXT));
`else
    assign access_err = 1'b0;
`endif

    // Outputs and array controls decoded from state; misses alias into data when unchecked
    always_comb begin
        req_ready_o  = (state_q == IDLE) && started_q;
        resp_valid_o = (state_q == RESP);
        resp_err_o   = resp_valid_o && access_err;
        ram_en       = (state_q == ACCESS);
        data_we      = ram_en && req_write_q && (region != TEXT) && !access_err;
        resp_rdata_o = rdata_q;
        if (resp_valid_o && !req_write_q) begin
            if (access_err) begin
                resp_rdata_o = '0;
            end else if (region == TEXT) begin
                resp_rdata_o = text_rdata;
            end else begin
                resp_rdata_o = data_rdata;
            end
        end
    end

    // Hold the last returned read data between responses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (state_q == RESP) begin
            rdata_q <= resp_rdata_o;
        end
    end

    mcu_word_ram #(.ADDR_W(AW)) u_text_ram (
        .clk_i   (clk_i),
        .en_i    (ram_en),
        .we_i    (1'b0),
        .addr_i  (text_off[AW+1:2]),
        .wdata_i (req_wdata_q),
        .rdata_o (text_rdata)
    );

    mcu_word_ram #(.ADDR_W(AW)) u_data_ram (
        .clk_i   (clk_i),
        .en_i    (ram_en),
        .we_i    (data_we),
        .addr_i  (data_off[AW+1:2]),
        .wdata_i (req_wdata_q),
        .rdata_o (data_rdata)
    );

endmodule

// File: tb/tb_mcu_mem_responder.sv
// tb/tb_mcu_mem_responder.sv - directed table-driven bench for mcu_mem_responder
module tb_mcu_mem_responder;

`ifdef MCU_MEM_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        int          d;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid  [2];
    logic        req_write  [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        req_ready  [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rd [2];
    vec_t vecs [17];

    mcu_mem_responder #(.WAIT_CYCLES(2)) dut_w2 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid[0]), .req_write_i(req_write[0]),
        .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
        .req_ready_o(req_ready[0]), .resp_valid_o(resp_valid[0]),
        .resp_rdata_o(resp_rdata[0]), .resp_err_o(resp_err[0])
    );

    mcu_mem_responder #(.WAIT_CYCLES(0)) dut_w0 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid[1]), .req_write_i(req_write[1]),
        .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
        .req_ready_o(req_ready[1]), .resp_valid_o(resp_valid[1]),
        .resp_rdata_o(resp_rdata[1]), .resp_err_o(resp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_req(input int d, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                           output logic err, output logic busy_rdy, output logic extra_valid);
        int waitc;
        lat = -1; rdata = '0; err = 1'b0; busy_rdy = 1'b0; extra_valid = 1'b0;
        @(negedge clk);
        req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = addr; req_wdata[d] = wdata;
        waitc = 0;
        while (!req_ready[d] && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (req_ready[d]) begin
            @(posedge clk);
            @(negedge clk);
            req_valid[d] = 1'b0;
            for (int k = 1; k <= 40; k++) begin
                if (req_ready[d]) busy_rdy = 1'b1;
                if (resp_valid[d]) begin
                    lat = k; rdata = resp_rdata[d]; err = resp_err[d];
                    break;
                end
                @(negedge clk);
            end
            if (lat > 0) begin
                @(negedge clk);
                extra_valid = resp_valid[d];
            end
        end else begin
            req_valid[d] = 1'b0;
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] rd, exp_rd;
        logic        er, busy, extra, saw;

        vecs[0]  = '{0, 1'b1, 32'h1001_0000, 32'h1111_0000, 32'h0, 1'b0, 4};
        vecs[1]  = '{0, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 32'h0, 1'b0, 4};
        vecs[2]  = '{0, 1'b0, 32'h1001_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 4};
        vecs[3]  = '{0, 1'b1, 32'h0040_0008, 32'h1234_5678, 32'h0, CHK, 4};
        vecs[4]  = '{0, 1'b0, 32'h0040_0008, 32'h0, 32'h0BAD_F00D, 1'b0, 4};
        vecs[5]  = '{0, 1'b0, 32'h1001_0002, 32'h0, CHK ? 32'h0 : 32'h1111_0000, CHK, 4};
        vecs[6]  = '{0, 1'b0, 32'h2000_0000, 32'h0, CHK ? 32'h0 : 32'h1111_0000, CHK, 4};
        vecs[7]  = '{0, 1'b0, 32'h0040_03FC, 32'h0, 32'h7E57_00FF, 1'b0, 4};
        vecs[8]  = '{0, 1'b0, 32'h0040_0400, 32'h0, CHK ? 32'h0 : 32'h1111_0000, CHK, 4};
        vecs[9]  = '{0, 1'b1, 32'h1001_03FC, 32'h5555_AAAA, 32'h0, 1'b0, 4};
        vecs[10] = '{0, 1'b0, 32'h1001_03FC, 32'h0, 32'h5555_AAAA, 1'b0, 4};
        vecs[11] = '{0, 1'b1, 32'h1001_0010, 32'h600D_0010, 32'h0, 1'b0, 4};
        vecs[12] = '{1, 1'b0, 32'h0040_0000, 32'h0, 32'hA0A0_0001, 1'b0, 2};
        vecs[13] = '{1, 1'b1, 32'h1001_0008, 32'hCAFE_F00D, 32'h0, 1'b0, 2};
        vecs[14] = '{1, 1'b0, 32'h1001_0008, 32'h0, 32'hCAFE_F00D, 1'b0, 2};
        vecs[15] = '{1, 1'b1, 32'h0040_0000, 32'hFFFF_FFFF, 32'h0, CHK, 2};
        vecs[16] = '{1, 1'b0, 32'h0040_0000, 32'h0, 32'hA0A0_0001, 1'b0, 2};

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
            last_rd[i] = '0;
        end
        dut_w2.u_text_ram.mem_q[2]   = 32'h0BAD_F00D;
        dut_w2.u_text_ram.mem_q[255] = 32'h7E57_00FF;
        dut_w0.u_text_ram.mem_q[0]   = 32'hA0A0_0001;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_ready%0d", i), 32'(req_ready[i]), 32'h0);
            chk($sformatf("rst_valid%0d", i), 32'(resp_valid[i]), 32'h0);
            chk($sformatf("rst_rdata%0d", i), resp_rdata[i], 32'h0);
            chk($sformatf("rst_err%0d", i), 32'(resp_err[i]), 32'h0);
        end
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 32'(req_ready[0]), 32'h0);
        @(negedge clk);
        chk("ready_after_release0", 32'(req_ready[0]), 32'h1);
        chk("ready_after_release1", 32'(req_ready[1]), 32'h1);

        for (int i = 0; i < 17; i++) begin
            run_req(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, rd, er, busy, extra);
            exp_rd = vecs[i].wr ? last_rd[vecs[i].d] : vecs[i].exp_rdata;
            last_rd[vecs[i].d] = exp_rd;
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_rdata", i), rd, exp_rd);
            chk($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_ready_in_flight", i), 32'(busy), 32'h0);
            chk($sformatf("v%0d_valid_one_cycle", i), 32'(extra), 32'h0);
        end

        @(negedge clk);
        req_valid[0] = 1'b1; req_write[0] = 1'b1;
        req_addr[0] = 32'h1001_0010; req_wdata[0] = 32'hBAD0_0010;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("abort_ready_in_wait", 32'(req_ready[0]), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("abort_ready_low", 32'(req_ready[0]), 32'h0);
        chk("abort_rdata_reset", resp_rdata[0], 32'h0);
        saw = resp_valid[0];
        repeat (2) begin
            @(negedge clk);
            saw = saw | resp_valid[0];
        end
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            saw = saw | resp_valid[0];
        end
        chk("abort_no_response", 32'(saw), 32'h0);
        last_rd[0] = '0;
        last_rd[1] = '0;

        run_req(0, 1'b0, 32'h1001_0010, 32'h0, lat, rd, er, busy, extra);
        chk("abort_latency", 32'(lat), 32'd4);
        chk("abort_old_value", rd, 32'h600D_0010);
        chk("abort_err", 32'(er), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcu_mem_responder.md
# mcu_mem_responder

- Memory-side responder for the multicycle RISC-V core's single shared instruction/data port.
- Accepts one read or write request at a time through a valid/ready handshake.
- Inserts a configurable number of wait states, then returns a registered response: read data or a write acknowledge.
- Holds a read-only text region and a read/write data region, each backed by a word RAM.

## Interface
- `ADDR_WORDS_LOG2`, default 8: word-address bits per region; each region holds 2^N 32-bit words.
- `WAIT_CYCLES`, default 2: wait states between request accept and response; legal range 0..15.
- `TEXT_BASE`, default 32'h0040_0000: byte base address of the text region.
- `DATA_BASE`, default 32'h1001_0000: byte base address of the data region.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-low.
- `req_valid`  in  1: request present. Held stable with all `req_*` fields until accepted.
- `req_write`  in  1: 1 = store, 0 = load or fetch.
- `req_addr`  in  32: byte address.
- `req_wdata`  in  32: store data.
- `req_ready`  out  1: responder can accept a request.
- `resp_valid`  out  1: one-cycle response strobe.
- `resp_rdata`  out  32: read data. Holds its last value between responses.
- `resp_err`  out  1: error flag, qualified by `resp_valid`.

## Operation
- FSM states and transitions:
  - IDLE: `req_ready`=1. `req_valid` captures address, write flag and data into request registers. Next state is WAIT if `WAIT_CYCLES`>0, else ACCESS.
  - WAIT: counter counts down from `WAIT_CYCLES`-1; go to ACCESS when it reaches 0.
  - ACCESS: the array is read or written on this edge; go to RESP.
  - RESP: `resp_valid`=1 for exactly one cycle; return to IDLE.
- Region decode, on the captured address: region = `addr - base`. Hit when the offset is below 2^(`ADDR_WORDS_LOG2`+2). Word index = offset[`ADDR_WORDS_LOG2`+1:2].
- Loads from either region return the stored word.
- Stores:
  - A store to the data region writes the full word.
  - A store to the text region is never committed.
- Response to a store: `resp_valid` with `resp_rdata` unchanged.
- Reset values: `req_ready`=0 while `rst` is low and 1 afterwards (IDLE). `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, counter=0, state IDLE.
- Reset is also the mid-operation abort: any pending store is dropped and no response is produced. Array contents are not cleared by reset.
- No new request is accepted while a request is in flight; only IDLE accepts.

## Timing
- Accept edge is T. `resp_valid` is high during cycle T+`WAIT_CYCLES`+2, where cycle T+1 is the first cycle after accept.
  - Example, `WAIT_CYCLES`=2: accept at T, WAIT, WAIT, ACCESS, RESP. `resp_valid` is high in the 4th cycle after accept.
- A store is visible to a load accepted after the store's RESP cycle.
- Minimum spacing between accepts is `WAIT_CYCLES`+3 cycles.
- `req_ready` depends only on state (registered), never combinationally on `req_valid`.

## Configuration
- `MCU_MEM_ADDR_CHECK_EN` defined:
  - `resp_err`=1 for a misaligned address (addr[1:0]≠0), an address hitting neither region, or a store to text.
  - Erroneous stores are not committed; erroneous loads return 0.
- `MCU_MEM_ADDR_CHECK_EN` undefined:
  - `resp_err` is tied 0.
  - addr[1:0] is ignored.
  - A miss aliases into the data region by word index.
  - Text stores are silently dropped.

## Structure
- Package `mcu_mem_pkg` holds:
  - State enum: IDLE=2'd0, WAIT=2'd1, ACCESS=2'd2, RESP=2'd3.
  - Default base-address constants.
  - Region-select enum: TEXT, DATA, NONE.
- Sub-module `mcu_word_ram` is instantiated once per region. It is a synchronous single-port 32-bit RAM with write enable and a registered read.

## Test plan
- Reset: hold `rst`=0 for 3 cycles. All outputs are 0. `req_ready` rises the first cycle after release.
- Round-trip, `WAIT_CYCLES`=2:
  - Store 32'hDEAD_BEEF to 32'h1001_0004 gives an ack with `resp_valid` exactly 4 cycles after accept.
  - A following load from 32'h1001_0004 returns 32'hDEAD_BEEF with `resp_err`=0.
- Zero wait states (`WAIT_CYCLES`=0): a load from 32'h0040_0000 returns the preloaded word 2 cycles after accept. `req_ready`=0 during ACCESS and RESP.
- Text protection: a store of 32'h1234_5678 to 32'h0040_0008 is followed by a load from the same address, which returns the original word. With the macro, the store's `resp_err`=1.
- Errors (macro on):
  - A load from 32'h1001_0002 gives `resp_err`=1 and `resp_rdata`=0.
  - A load from 32'h2000_0000 gives `resp_err`=1.
- Reset mid-operation:
  - Assert `rst` during WAIT of a store to 32'h1001_0010.
  - No `resp_valid` is produced.
  - A later load from that address returns the old value.
